muldiv_unit: RTL and testbench

Iterative 32-bit unsigned multiply/divide unit in the execute stage of the mini MIPS processor. It consumes the two operands read from the register block (`readData1`, `readData2`) and holds the 64-bit result in internal HI/LO registers. The write-back mux reads HI/LO and routes them through the register block's `writeData` path on `mfhi`/`mflo`. Control stalls the pipeline while the unit is busy.

---
 rtl/muldiv_unit.sv | 126 ++++++++++++
 tb/tb_muldiv_unit.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply/divide unit: shift-add MULTU and restoring DIVU,
// one bit per cycle, with results held in HI/LO registers.
module muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CntW = $clog2(WIDTH) + 1;
    localparam logic [CntW-1:0] LastIter = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e             r_state;
    state_e             w_state_nxt;
    logic [CntW-1:0]    r_cnt;
    logic               r_op;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH:0]     r_rem;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_accept;
    logic               w_last;
    logic               w_mbit;
    logic [WIDTH-1:0]   w_addend;
    logic [WIDTH:0]     w_msum;
    logic [2*WIDTH-1:0] w_acc_nxt;
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH+1:0]   w_diff;
    logic               w_qbit;
    logic [WIDTH:0]     w_rem_nxt;
    logic [WIDTH-1:0]   w_quot_nxt;

    assign w_accept = (r_state == StIdle) && start;
    assign w_last   = (r_state == StRun) && (r_cnt == LastIter);

    // MULTU: add the multiplicand into the upper half, then shift the whole
    // accumulator right so each multiplier bit lands at its own weight.
    assign w_mbit    = r_b[r_cnt[CntW-2:0]];
    assign w_addend  = w_mbit ? r_a : '0;
    assign w_msum    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};
    assign w_acc_nxt = {w_msum, r_acc[WIDTH-1:1]};

    // DIVU: r_a doubles as the dividend shifter and the quotient collector.
    assign w_rem_sh   = {r_rem[WIDTH-1:0], r_a[WIDTH-1]};
    assign w_diff     = {1'b0, w_rem_sh} - {2'b00, r_b};
    assign w_qbit     = ~w_diff[WIDTH+1];
    assign w_rem_nxt  = w_qbit ? w_diff[WIDTH:0] : w_rem_sh;
    assign w_quot_nxt = {r_a[WIDTH-2:0], w_qbit};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            StIdle:  if (start) w_state_nxt = StRun;
            StRun:   if (w_last) w_state_nxt = StDone;
            StDone:  w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    always_comb begin
        busy = (r_state != StIdle);
        done = (r_state == StDone);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
            r_op  <= 1'b0;
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
            r_rem <= '0;
            r_hi  <= '0;
            r_lo  <= '0;
        end else if (w_accept) begin
            r_cnt <= '0;
            r_op  <= op;
            r_a   <= a;
            r_b   <= b;
            r_acc <= '0;
            r_rem <= '0;
        end else if (r_state == StRun) begin
            r_cnt <= r_cnt + CntW'(1);
            if (r_op) begin
                r_a   <= w_quot_nxt;
                r_rem <= w_rem_nxt;
            end else begin
                r_acc <= w_acc_nxt;
            end
            if (w_last) begin
                if (r_op) begin
                    r_hi <= w_rem_nxt[WIDTH-1:0];
                    r_lo <= w_quot_nxt;
                end else begin
                    r_hi <= w_acc_nxt[2*WIDTH-1:WIDTH];
                    r_lo <= w_acc_nxt[WIDTH-1:0];
                end
            end
        end
    end

    assign hi = r_hi;
    assign lo = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and randomized checks of muldiv_unit against an arithmetic reference
// model: latency, done width, HI/LO hold, ignored starts, reset abort.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int errors = 0;
    int checks = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .op   (op),
        .a    (a),
        .b    (b),
        .busy (busy),
        .done (done),
        .hi   (hi),
        .lo   (lo)
    );

    initial forever #5 clk = ~clk;

    // Returns {hi, lo} as the architecture defines them.
    function automatic logic [63:0] ref_model(input logic o, input logic [31:0] x,
                                              input logic [31:0] y);
        if (!o) return {32'd0, x} * {32'd0, y};
        if (y == 32'd0) return {x, 32'hFFFFFFFF};
        return {x % y, x / y};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one op from IDLE, then check latency, hold, result and done width.
    task automatic run_op(input string tag, input logic o, input logic [31:0] x,
                          input logic [31:0] y);
        logic [63:0] held;
        int          cyc;
        bit          hold_ok;
        held  = {hi, lo};
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        step();
        check({tag, " busy@accept"}, 64'(busy), 64'd1);
        check({tag, " done@accept"}, 64'(done), 64'd0);
        start   = 1'b0;
        op      = ~o;
        a       = $urandom;
        b       = $urandom;
        cyc     = 0;
        hold_ok = 1'b1;
        while (!done && cyc < 40) begin
            if ({hi, lo} !== held) hold_ok = 1'b0;
            step();
            cyc++;
        end
        check({tag, " latency"}, 64'(cyc), 64'd32);
        check({tag, " hold"}, 64'(hold_ok), 64'd1);
        check({tag, " result"}, {hi, lo}, ref_model(o, x, y));
        check({tag, " busy@done"}, 64'(busy), 64'd1);
        step();
        check({tag, " done width"}, 64'(done), 64'd0);
        check({tag, " idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int          ndone;
        bit          hold_ok;
        int          cyc;
        logic        ro;
        logic [31:0] rx;
        logic [31:0] ry;

        // Reset held with start high
        reset = 1'b1;
        start = 1'b1;
        op    = 1'b0;
        a     = 32'd5;
        b     = 32'd5;
        step();
        step();
        check("rst busy", 64'(busy), 64'd0);
        check("rst done", 64'(done), 64'd0);
        check("rst hilo", {hi, lo}, 64'd0);
        reset = 1'b0;
        start = 1'b0;
        step();
        check("rst no start", 64'(busy), 64'd0);

        run_op("mul max", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
        check("mul max const", {hi, lo}, 64'hFFFFFFFE_00000001);
        run_op("div 100/7", 1'b1, 32'd100, 32'd7);
        check("div 100/7 const", {hi, lo}, {32'd2, 32'd14});
        run_op("div by 0", 1'b1, 32'd5, 32'd0);
        check("div by 0 const", {hi, lo}, {32'd5, 32'hFFFFFFFF});

        // Starts during RUN and DONE are ignored
        start = 1'b1;
        op    = 1'b0;
        a     = 32'd3;
        b     = 32'd4;
        step();
        start = 1'b0;
        op    = 1'b1;
        a     = 32'd9;
        b     = 32'd3;
        ndone = 0;
        for (int c = 1; c <= 32; c++) begin
            step();
            if (done) ndone++;
            start = (c == 4) || (c == 32);
        end
        check("ign done@32", 64'(done), 64'd1);
        check("ign result", {hi, lo}, {32'd0, 32'd12});
        step();
        start = 1'b0;
        check("ign idle", 64'(busy), 64'd0);
        step();
        check("ign no restart", 64'(busy), 64'd0);
        for (int c = 0; c < 36; c++) begin
            step();
            if (done) ndone++;
        end
        check("ign single done", 64'(ndone), 64'd1);

        // Reset mid-operation
        start = 1'b1;
        op    = 1'b0;
        a     = 32'd6;
        b     = 32'd7;
        step();
        start = 1'b0;
        repeat (10) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort busy", 64'(busy), 64'd0);
        check("abort done", 64'(done), 64'd0);
        check("abort hilo", {hi, lo}, 64'd0);
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (done || busy) ndone++;
        end
        check("abort quiet", 64'(ndone), 64'd0);
        run_op("mul 6x7", 1'b0, 32'd6, 32'd7);

        // Back-to-back with start held high
        start = 1'b1;
        op    = 1'b0;
        a     = 32'd2;
        b     = 32'd3;
        step();
        op = 1'b1;
        a  = 32'd10;
        b  = 32'd4;
        repeat (32) step();
        check("b2b first done", 64'(done), 64'd1);
        check("b2b first result", {hi, lo}, {32'd0, 32'd6});
        step();
        check("b2b idle@k+33", 64'(busy), 64'd0);
        step();
        check("b2b accept@k+34", 64'(busy), 64'd1);
        start   = 1'b0;
        cyc     = 0;
        hold_ok = 1'b1;
        while (!done && cyc < 40) begin
            if ({hi, lo} !== {32'd0, 32'd6}) hold_ok = 1'b0;
            step();
            cyc++;
        end
        check("b2b second latency", 64'(cyc), 64'd32);
        check("b2b hold", 64'(hold_ok), 64'd1);
        check("b2b second result", {hi, lo}, {32'd2, 32'd2});
        step();

        // Randomized operands, including small and zero divisors
        for (int i = 0; i < 16; i++) begin
            ro = 1'($urandom_range(0, 1));
            rx = $urandom;
            ry = (i % 4 == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            run_op(ro ? "rand div" : "rand mul", ro, rx, ry);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
